// File: rtl/c2c_data_ram_if.sv
// c2c data-side bus interfaces: c2c_r (read) and c2c_w (write).
// The master drives the strobe, address, byte-count select and (for writes) data.
// The slave returns a single-cycle registered ack and, for reads, the read data.
interface c2c_r #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [3:0]      sel;
  logic            re;
  logic [XLEN-1:0] data;
  logic            ack;

  modport master (output addr, output sel, output re, input data, input ack);
  modport slave  (input addr, input sel, input re, output data, output ack);
endinterface

interface c2c_w #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [3:0]      sel;
  logic [XLEN-1:0] data;
  logic            we;
  logic            ack;

  modport master (output addr, output sel, output data, output we, input ack);
  modport slave  (input addr, input sel, input data, input we, output ack);
endinterface

// File: rtl/c2c_data_ram.sv
// Byte-addressed data RAM answering the core's c2c read and write buses.
// Ports:
//   clk, rst_n  - core clock, asynchronous active-low reset
//   data_bus_r  - c2c_r slave: addr/sel/re in, data/ack out
//   data_bus_w  - c2c_w slave: addr/sel/data/we in, ack out
// Data is right-justified; byte k of an access lives at (addr + k) mod DEPTH_BYTES.
// Every ack is a registered, single-cycle pulse, WAIT_STATES+2 cycles after capture.
module c2c_data_ram #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input logic clk,
  input logic rst_n,
  c2c_r.slave data_bus_r,
  c2c_w.slave data_bus_w
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  logic [7:0]       r_mem [DEPTH_BYTES];

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  logic [AW-1:0]    r_addr;
  logic [3:0]       r_mask;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_rdata;
  logic             r_rack;
  logic             r_wack;

  logic [AW-1:0]    w_baddr_c [4];
  logic [XLEN-1:0]  w_rdata_c;
  logic             w_strobe_lost_c;

  // Byte-count select to byte-lane mask; unknown encodings mean a full word.
  function automatic logic [3:0] sel_to_mask(input logic [3:0] sel);
    case (sel)
      4'b0001: sel_to_mask = 4'b0001;
      4'b0011: sel_to_mask = 4'b0011;
      default: sel_to_mask = 4'b1111;
    endcase
  endfunction

  // Per-byte addresses wrap naturally in AW bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_baddr_c[k] = r_addr + AW'(k);
    end
  end

  // Gather the selected bytes; unselected lanes read as zero.
  always_comb begin
    w_rdata_c = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_mask[k]) begin
        w_rdata_c[8*k +: 8] = r_mem[w_baddr_c[k]];
      end
    end
  end

  assign w_strobe_lost_c = r_is_wr ? !data_bus_w.we : !data_bus_r.re;

  // Request FSM; acks are set on the edge leaving COMMIT so they are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rack  <= 1'b0;
      r_wack  <= 1'b0;
    end else begin
      r_rack <= 1'b0;
      r_wack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_bus_w.we) begin
            r_is_wr <= 1'b1;
            r_addr  <= AW'(data_bus_w.addr);
            r_mask  <= sel_to_mask(data_bus_w.sel);
            r_wdata <= data_bus_w.data;
            r_cnt   <= CNT_W'(WAIT_STATES - 1);
            r_state <= (WAIT_STATES == 0) ? ST_COMMIT : ST_WAIT;
          end else if (data_bus_r.re) begin
            r_is_wr <= 1'b0;
            r_addr  <= AW'(data_bus_r.addr);
            r_mask  <= sel_to_mask(data_bus_r.sel);
            r_cnt   <= CNT_W'(WAIT_STATES - 1);
            r_state <= (WAIT_STATES == 0) ? ST_COMMIT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_strobe_lost_c) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (!r_is_wr) begin
            r_rdata <= w_rdata_c;
          end
          r_rack  <= !r_is_wr;
          r_wack  <= r_is_wr;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory array is never reset; writes land on the edge leaving COMMIT.
  always_ff @(posedge clk) begin
    if (r_state == ST_COMMIT && r_is_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (r_mask[k]) begin
          r_mem[w_baddr_c[k]] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

  assign data_bus_r.data = r_rdata;
  assign data_bus_r.ack  = r_rack;
  assign data_bus_w.ack  = r_wack;

endmodule

// File: tb/tb_c2c_data_ram.sv
// Self-checking bench for c2c_data_ram: a WAIT_STATES=1 instance for the main
// vector table and reset cases, and a WAIT_STATES=3 instance for strobe abort.
module tb_c2c_data_ram;

  logic clk;
  logic rst_n;

  c2c_r #(.XLEN(32)) r_if  ();
  c2c_w #(.XLEN(32)) w_if  ();
  c2c_r #(.XLEN(32)) r_if3 ();
  c2c_w #(.XLEN(32)) w_if3 ();

  c2c_data_ram #(.DEPTH_BYTES(4096), .WAIT_STATES(1), .INIT_FILE("")) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_bus_r (r_if),
    .data_bus_w (w_if)
  );

  c2c_data_ram #(.DEPTH_BYTES(4096), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_bus_r (r_if3),
    .data_bus_w (w_if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_bus(input int u, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    if (u == 0) begin
      w_if.we = wr; w_if.addr = a; w_if.sel = s; w_if.data = d;
      r_if.re = rd; r_if.addr = a; r_if.sel = s;
    end else begin
      w_if3.we = wr; w_if3.addr = a; w_if3.sel = s; w_if3.data = d;
      r_if3.re = rd; r_if3.addr = a; r_if3.sel = s;
    end
  endtask

  function automatic logic get_rack(input int u);
    return (u == 0) ? r_if.ack : r_if3.ack;
  endfunction

  function automatic logic get_wack(input int u);
    return (u == 0) ? w_if.ack : w_if3.ack;
  endfunction

  function automatic logic [31:0] get_rdata(input int u);
    return (u == 0) ? r_if.data : r_if3.data;
  endfunction

  // One access; strobes drop on the ack cycle like a real master. Watches a
  // fixed window so a missing ack, a late ack or a repeated ack are all caught.
  task automatic xfer(input int u, input bit wr, input bit rd, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rdat, output int lat, output int nr, output int nw);
    @(negedge clk);
    set_bus(u, wr, rd, a, s, d);
    rdat = '0; lat = 0; nr = 0; nw = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (get_rack(u)) begin nr++; rdat = get_rdata(u); if (lat == 0) lat = c; end
      if (get_wack(u)) begin nw++; if (lat == 0) lat = c; end
      if (lat != 0) set_bus(u, 1'b0, 1'b0, a, s, d);
    end
    set_bus(u, 1'b0, 1'b0, a, s, d);
  endtask

  function automatic vec_t mk(input bit wr, input bit rd, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.sel = s; v.wdata = d; v.exp_rdata = e;
    return v;
  endfunction

  initial begin
    logic [31:0] rdat;
    int lat, nr, nw;
    int n_ack;

    // Directed vectors for the WAIT_STATES=1 instance (latency 3).
    vecs.push_back(mk(1, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 32'h0000_0101, 4'b0001, 32'h1234_56AA, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_AAEF));
    vecs.push_back(mk(0, 1, 32'h0000_0103, 4'b0001, 32'h0,         32'h0000_00DE));
    vecs.push_back(mk(1, 0, 32'h0000_0FFE, 4'b1111, 32'h1122_3344, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0FFF, 4'b0011, 32'h0,         32'h0000_2233));
    vecs.push_back(mk(0, 1, 32'h0000_0000, 4'b0001, 32'h0,         32'h0000_0022));
    vecs.push_back(mk(0, 1, 32'h1000_0FFE, 4'b1111, 32'h0,         32'h1122_3344));
    vecs.push_back(mk(1, 0, 32'h0000_0200, 4'b1111, 32'h0102_0304, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0000_0200, 4'b0011, 32'hCAFE_BABE, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0200, 4'b1111, 32'h0,         32'h0102_BABE));
    vecs.push_back(mk(1, 0, 32'h0000_0300, 4'b0101, 32'hA5A5_5A5A, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0300, 4'b0011, 32'h0,         32'h0000_5A5A));
    vecs.push_back(mk(0, 1, 32'h0000_0300, 4'b0000, 32'h0,         32'hA5A5_5A5A));
    vecs.push_back(mk(1, 1, 32'h0000_0020, 4'b0001, 32'h0000_0055, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0020, 4'b0001, 32'h0,         32'h0000_0055));

    rst_n = 1'b0;
    set_bus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset r.ack",   32'(r_if.ack),  32'h0);
    check("reset w.ack",   32'(w_if.ack),  32'h0);
    check("reset r.data",  r_if.data,      32'h0);
    check("reset3 r.data", r_if3.data,     32'h0);

    foreach (vecs[i]) begin
      xfer(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].sel, vecs[i].wdata, rdat, lat, nr, nw);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d w.ack pulses", i), 32'(nw), 32'd1);
        check($sformatf("vec%0d r.ack pulses", i), 32'(nr), 32'd0);
      end else begin
        check($sformatf("vec%0d r.ack pulses", i), 32'(nr), 32'd1);
        check($sformatf("vec%0d w.ack pulses", i), 32'(nw), 32'd0);
        check($sformatf("vec%0d r.data", i), rdat, vecs[i].exp_rdata);
      end
    end

    // A write leaves the read data register untouched; a later read sees it.
    xfer(0, 1'b1, 1'b0, 32'h20, 4'b0001, 32'h0000_0077, rdat, lat, nr, nw);
    check("r.data held across write", r_if.data, 32'h0000_0055);
    xfer(0, 1'b0, 1'b1, 32'h20, 4'b0001, 32'h0, rdat, lat, nr, nw);
    check("read-after-write", rdat, 32'h0000_0077);

    // Abort: read strobe dropped one cycle after capture on the 3-wait-state RAM.
    @(negedge clk);
    set_bus(1, 1'b0, 1'b1, 32'h40, 4'b1111, 32'h0);
    @(negedge clk);
    set_bus(1, 1'b0, 1'b0, 32'h40, 4'b1111, 32'h0);
    n_ack = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (r_if3.ack || w_if3.ack) n_ack++;
    end
    check("abort no ack", 32'(n_ack), 32'd0);
    xfer(1, 1'b1, 1'b0, 32'h80, 4'b1111, 32'h5A5A_A5A5, rdat, lat, nr, nw);
    check("post-abort write latency", 32'(lat), 32'd5);
    check("post-abort w.ack pulses",  32'(nw),  32'd1);
    xfer(1, 1'b0, 1'b1, 32'h80, 4'b1111, 32'h0, rdat, lat, nr, nw);
    check("post-abort read data",     rdat,     32'h5A5A_A5A5);

    // Reset during WAIT: the write is dropped and the old word survives.
    xfer(0, 1'b1, 1'b0, 32'h400, 4'b1111, 32'h0BAD_F00D, rdat, lat, nr, nw);
    @(negedge clk);
    set_bus(0, 1'b1, 1'b0, 32'h400, 4'b1111, 32'hFFFF_FFFF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset-in-wait w.ack", 32'(w_if.ack), 32'h0);
    set_bus(0, 1'b0, 1'b0, 32'h400, 4'b1111, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 1'b1, 32'h400, 4'b1111, 32'h0, rdat, lat, nr, nw);
    check("reset-in-wait word kept",   rdat,      32'h0BAD_F00D);
    check("post-reset read latency",   32'(lat),  32'd3);

    // Reset while w.ack is high: ack must fall before the next clock edge.
    @(negedge clk);
    set_bus(0, 1'b1, 1'b0, 32'h404, 4'b1111, 32'h1357_9BDF);
    n_ack = 0;
    for (int c = 0; c < 10 && n_ack == 0; c++) begin
      @(negedge clk);
      if (w_if.ack) n_ack = 1;
    end
    check("ack before async reset", 32'(n_ack), 32'd1);
    set_bus(0, 1'b0, 1'b0, 32'h404, 4'b1111, 32'h0);
    #1 rst_n = 1'b0;
    #1 check("async reset clears w.ack", 32'(w_if.ack), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 1'b1, 32'h404, 4'b1111, 32'h0, rdat, lat, nr, nw);
    check("committed write survives reset", rdat, 32'h1357_9BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
